med_ctrl: RTL and testbench
===========================

# med_ctrl

Sequencer and input buffer for the 9-tap median datapath (MED). It collects a window of `number` pixels in an internal FIFO, then drives MED's DI/DSI/BYP through a load phase and a fixed schedule of compare/bypass passes. It flags the single cycle in which MED's DO carries the window median. It sits between the pixel stream source and MED; DO itself is taken directly from MED.

## Interface
- `width`, 8: pixel width in bits.
- `number`, 9: window size; odd, ≥3; must match MED's `number`.

- `CLK`  in  1  clock; all state updates on rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `PIX_IN`  in  width  incoming pixel.
- `PIX_VALID`  in  1  PIX_IN valid.
- `PIX_READY`  out  1  FIFO can accept; a push happens when PIX_VALID && PIX_READY.
- `DI`  out  width  to MED DI; equals the FIFO head.
- `DSI`  out  1  to MED DSI.
- `BYP`  out  1  to MED BYP.
- `DSO`  out  1  1-cycle pulse; MED DO holds the median during this cycle.

## Operation
- FIFO depth is `number`, with registered count `0..number`.
  - `PIX_READY = (count < number)`; there is no push-when-full bypass.
  - A push and a pop in the same cycle leave count unchanged.
- States: IDLE, LOAD, SORT, DONE.
- IDLE: DSI=0, BYP=1. If count==number, go to LOAD at the next edge.
- LOAD: `number` cycles.
  - Outputs: DSI=1, BYP=1, DI = FIFO head.
  - Pop one entry every cycle. Pushes remain allowed.
- SORT: DSI=0, with P = (number-1)/2 passes.
  - Pass p, for p = 0..P-1: (number-1-p) cycles with BYP=0, then (p+1) cycles with BYP=1. Each pass is `number` cycles.
  - Final pass: P cycles with BYP=0.
  - Total SORT length is P·number + P cycles; for number=9 this is 40.
- DONE: 1 cycle. DSO=1, DSI=0, BYP=1. Next state is LOAD if count==number, else IDLE.
- Counters:
  - A phase-cycle counter runs 0..number-1 and wraps.
  - A pass counter runs 0..P.
  - Both clear on every entry to LOAD and to SORT.
- There is no consumer backpressure. DSO is advisory; the consumer must sample DO in the DSO cycle.
- MED has no enable, so the data contents outside LOAD/SORT are don't-care. The controller must never assert DSI=1 outside LOAD.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE, count=0, FIFO pointers=0.
  - DSO=0, DSI=0, BYP=1, PIX_READY=1.
  - DI = FIFO head (don't-care).
- Reset mid-LOAD or mid-SORT aborts the window; no DSO is issued, and FIFO contents are discarded.
- Window latency, with c = the IDLE cycle in which count==number is seen:
  - LOAD occupies c+1..c+number.
  - SORT occupies c+number+1..c+number+P·(number+1).
  - DONE (DSO=1) is at c+50 for number=9.
- Steady-state throughput: if the FIFO refills during LOAD/SORT, DONE goes directly to LOAD. The period is 1 + number + P·(number+1) cycles, which is 50 for number=9.
- All outputs are Moore outputs from registered state and counters, except DI (FIFO head read) and PIX_READY (from count).
- Pushes during LOAD are accepted whenever count < number. The first pop frees space in the cycle after it.

## Test plan
- Reset: hold nRST=0, then release. Require DSO=0, DSI=0, BYP=1, PIX_READY=1. DSO must stay 0 with no input.
- Single window: push 9,1,8,2,7,3,6,4,5. Require DSO exactly 50 cycles after the IDLE cycle that sees the FIFO full, with DO=5 in that cycle. DSI must be 1 for exactly 9 consecutive cycles.
- Duplicates and extremes: window 255,255,255,0,0,0,0,255,0 -> DO=0 at DSO. Window of nine 0x80 -> DO=0x80.
- Back-to-back: stream 27 pixels (windows sorted ascending, descending, random) with PIX_VALID always 1. Require three DSO pulses exactly 50 cycles apart, with medians matching a reference model.
- Backpressure and gaps: randomly drop PIX_VALID.
  - PIX_READY=0 whenever count==9.
  - No pixel is lost or duplicated.
  - LOAD starts only when count==9.
- Reset mid-SORT: assert nRST 20 cycles into SORT. Require immediate IDLE and DSO=0. A subsequent fresh window must return the correct median.

Source files
------------

// File: rtl/med_ctrl.sv
// Sequencer and input FIFO for the 9-tap median datapath: buffers a window of pixels,
// then drives DI/DSI/BYP through a load phase and the compare/bypass schedule, pulsing DSO.
module med_ctrl #(
    parameter int unsigned width  = 8,
    parameter int unsigned number = 9
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [width-1:0] PIX_IN,
    input  logic             PIX_VALID,
    output logic             PIX_READY,
    output logic [width-1:0] DI,
    output logic             DSI,
    output logic             BYP,
    output logic             DSO
);

    localparam int unsigned Passes = (number - 1) / 2;
    localparam int unsigned PtrW   = $clog2(number);
    localparam int unsigned CntW   = $clog2(number + 1);

    localparam logic [PtrW-1:0] LastIdx  = PtrW'(number - 1);
    localparam logic [PtrW-1:0] LastPass = PtrW'(Passes);
    localparam logic [PtrW-1:0] FinalEnd = PtrW'(Passes - 1);
    localparam logic [PtrW-1:0] One      = PtrW'(1);
    localparam logic [CntW-1:0] Full     = CntW'(number);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StSort, StDone} state_e;

    state_e           state_q, state_d;
    logic [width-1:0] mem_q [number];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic [PtrW-1:0]  phase_q, phase_d;
    logic [PtrW-1:0]  pass_q, pass_d;
    logic             push, pop;

    assign PIX_READY = (count_q < Full);
    assign push      = PIX_VALID && PIX_READY;
    assign pop       = (state_q == StLoad);
    assign DI        = mem_q[rd_ptr_q];

    // Storage needs no reset; contents are only read after being written.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= PIX_IN;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + One;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + One;
            end
            if (push && !pop) begin
                count_q <= count_q + CntOne;
            end else if (pop && !push) begin
                count_q <= count_q - CntOne;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            phase_q <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pass_d  = pass_q;
        DSI     = 1'b0;
        BYP     = 1'b1;
        DSO     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q == Full) begin
                    state_d = StLoad;
                    phase_d = '0;
                    pass_d  = '0;
                end
            end
            StLoad: begin
                DSI = 1'b1;
                if (phase_q == LastIdx) begin
                    state_d = StSort;
                    phase_d = '0;
                    pass_d  = '0;
                end else begin
                    phase_d = phase_q + One;
                end
            end
            StSort: begin
                if (pass_q == LastPass) begin
                    // Closing pass: compare only, Passes cycles long.
                    BYP = 1'b0;
                    if (phase_q == FinalEnd) begin
                        state_d = StDone;
                    end else begin
                        phase_d = phase_q + One;
                    end
                end else begin
                    // Pass p compares for number-1-p cycles, then bypasses p+1 cycles.
                    BYP = (phase_q >= (LastIdx - pass_q));
                    if (phase_q == LastIdx) begin
                        phase_d = '0;
                        pass_d  = pass_q + One;
                    end else begin
                        phase_d = phase_q + One;
                    end
                end
            end
            StDone: begin
                DSO = 1'b1;
                if (count_q == Full) begin
                    state_d = StLoad;
                    phase_d = '0;
                    pass_d  = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_med_ctrl.sv
// Bench for med_ctrl: scoreboards pushed pixels against DI during load, models MED's DO as the
// median of the loaded window, and checks the output schedule cycle by cycle.
module tb_med_ctrl;

    localparam int W    = 8;
    localparam int N    = 9;
    localparam int P    = (N - 1) / 2;
    localparam int LAST = N + P * (N + 1) + 1;  // DONE offset from the full-detect cycle

    logic         clk = 1'b0;
    logic         n_rst;
    logic [W-1:0] pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic [W-1:0] di;
    logic         dsi, byp, dso;

    always #5 clk = ~clk;

    med_ctrl #(.width(W), .number(N)) dut (
        .CLK      (clk),
        .nRST     (n_rst),
        .PIX_IN   (pix_in),
        .PIX_VALID(pix_valid),
        .PIX_READY(pix_ready),
        .DI       (di),
        .DSI      (dsi),
        .BYP      (byp),
        .DSO      (dso)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0] pix_q [$];
    logic [W-1:0] med_q [$];
    logic [W-1:0] win   [$];
    logic [W-1:0] cap   [$];
    logic [W-1:0] do_hist [$];
    int           dso_cyc [$];
    int           start_cyc [$];
    int           cyc = 0;
    int           t = 0;
    bit           busy = 0;
    int           model_count = 0;

    logic [W-1:0] w_seq  [9] = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    logic [W-1:0] w_dup  [9] = '{255, 255, 255, 0, 0, 0, 0, 255, 0};
    logic [W-1:0] w_flat [9] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    logic [W-1:0] w_asc  [9] = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
    logic [W-1:0] w_desc [9] = '{200, 190, 180, 170, 160, 150, 140, 130, 120};
    logic [W-1:0] w_mix  [9] = '{40, 10, 30, 20, 50, 90, 60, 80, 70};
    logic [W-1:0] w_rnd  [9];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] median_of(input logic [W-1:0] v [$]);
        logic [W-1:0] a [$];
        a = v;
        a.sort();
        return a[N / 2];
    endfunction

    // Monitor: samples on the falling edge, between active edges.
    always @(negedge clk) begin
        bit       mpush, mpop, e_dsi, e_byp, e_dso;
        int       s, ps, ph;
        cyc++;
        if (!n_rst) begin
            check("rst_dso", dso, 0);
            check("rst_dsi", dsi, 0);
            check("rst_byp", byp, 1);
            check("rst_ready", pix_ready, 1);
            busy = 0;
            t = 0;
            model_count = 0;
            pix_q.delete();
            med_q.delete();
            win.delete();
            cap.delete();
            start_cyc.delete();
        end else begin
            mpush = pix_valid && pix_ready;
            mpop  = dsi;
            check("ready", pix_ready, model_count < N);
            if (busy) t++;
            e_dsi = 0;
            e_byp = 1;
            e_dso = 0;
            if (busy) begin
                if (t <= N) begin
                    e_dsi = 1;
                end else if (t < LAST) begin
                    s  = t - N - 1;
                    ps = s / N;
                    ph = s % N;
                    e_byp = (ps < P) ? (ph >= N - 1 - ps) : 1'b0;
                end else begin
                    e_dso = 1;
                end
            end
            check("dsi", dsi, e_dsi);
            check("byp", byp, e_byp);
            check("dso", dso, e_dso);
            if (dsi) begin
                check("di_avail", pix_q.size() > 0, 1);
                if (pix_q.size() > 0) check("di", di, pix_q.pop_front());
                cap.push_back(di);
            end
            if (dso) begin
                logic [W-1:0] do_model;
                check("win_size", cap.size(), N);
                do_model = median_of(cap);
                check("med_avail", med_q.size() > 0, 1);
                if (med_q.size() > 0) check("median", do_model, med_q.pop_front());
                check("start_avail", start_cyc.size() > 0, 1);
                if (start_cyc.size() > 0) check("latency", cyc - start_cyc.pop_front(), LAST);
                do_hist.push_back(do_model);
                dso_cyc.push_back(cyc);
                cap.delete();
            end
            if (mpush) begin
                pix_q.push_back(pix_in);
                win.push_back(pix_in);
                if (win.size() == N) begin
                    med_q.push_back(median_of(win));
                    win.delete();
                end
            end
            if (busy && t == LAST) busy = 0;
            if (!busy && model_count == N) begin
                busy = 1;
                t = 0;
                start_cyc.push_back(cyc);
            end
            model_count = model_count + int'(mpush) - int'(mpop);
        end
    end

    // Inputs change 2 time units after the rising edge.
    task automatic push_pix(input logic [W-1:0] v);
        bit acc = 0;
        int g;
        pix_in    = v;
        pix_valid = 1'b1;
        for (g = 0; g < 200 && !acc; g++) begin
            acc = pix_ready;
            @(posedge clk);
            #2;
        end
        pix_valid = 1'b0;
        check("push_accepted", acc, 1);
    endtask

    task automatic push_win(input logic [W-1:0] w [9], input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
            push_pix(w[i]);
        end
    endtask

    task automatic wait_dso(input int n);
        for (int g = 0; g < 300 && dso_cyc.size() < n; g++) begin
            @(posedge clk);
            #2;
        end
        check("wait_dso", dso_cyc.size(), n);
    endtask

    initial begin
        int base;
        n_rst     = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_dso", dso, 0);
        check("reset_dsi", dsi, 0);
        check("reset_byp", byp, 1);
        check("reset_ready", pix_ready, 1);
        n_rst = 1'b1;
        repeat (20) begin @(posedge clk); #2; end
        check("idle_dso_count", dso_cyc.size(), 0);

        // Single window
        base = dso_cyc.size();
        push_win(w_seq, 0);
        wait_dso(base + 1);
        check("w_seq_do", do_hist[do_hist.size() - 1], 5);

        // Duplicates and extremes
        base = dso_cyc.size();
        push_win(w_dup, 0);
        wait_dso(base + 1);
        check("w_dup_do", do_hist[do_hist.size() - 1], 0);
        base = dso_cyc.size();
        push_win(w_flat, 0);
        wait_dso(base + 1);
        check("w_flat_do", do_hist[do_hist.size() - 1], 8'h80);

        // Back-to-back, PIX_VALID held high
        for (int i = 0; i < N; i++) w_rnd[i] = W'($urandom_range(0, 255));
        base = dso_cyc.size();
        push_win(w_asc, 0);
        push_win(w_desc, 0);
        push_win(w_rnd, 0);
        wait_dso(base + 3);
        if (dso_cyc.size() >= base + 3) begin
            check("b2b_gap1", dso_cyc[base + 1] - dso_cyc[base], LAST);
            check("b2b_gap2", dso_cyc[base + 2] - dso_cyc[base + 1], LAST);
            check("b2b_asc_do", do_hist[base], 50);
            check("b2b_desc_do", do_hist[base + 1], 160);
        end

        // Random gaps
        base = dso_cyc.size();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) w_rnd[i] = W'($urandom_range(0, 255));
            push_win(w_rnd, 1);
        end
        wait_dso(base + 4);

        // Reset 20 cycles into SORT
        base = dso_cyc.size();
        push_win(w_asc, 0);
        for (int g = 0; g < 100 && !dsi; g++) begin @(posedge clk); #2; end
        check("load_seen", dsi, 1);
        for (int g = 0; g < 100 && dsi; g++) begin @(posedge clk); #2; end
        check("sort_seen", dsi, 0);
        repeat (20) begin @(posedge clk); #2; end
        n_rst = 1'b0;
        #1;
        check("abort_dso", dso, 0);
        check("abort_dsi", dsi, 0);
        check("abort_byp", byp, 1);
        @(posedge clk);
        #2;
        n_rst = 1'b1;
        repeat (60) begin @(posedge clk); #2; end
        check("abort_no_dso", dso_cyc.size(), base);
        push_win(w_mix, 0);
        wait_dso(base + 1);
        check("fresh_do", do_hist[do_hist.size() - 1], 50);

        for (int g = 0; g < 200 && (busy || pix_q.size() > 0 || med_q.size() > 0); g++) begin
            @(posedge clk);
            #2;
        end
        check("drain_pix", pix_q.size(), 0);
        check("drain_med", med_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
